// File: rtl/seq_chk_pkg.sv
// Shared types and helpers for the seq_repeat_chk checker family.
// Optional statistics build: SEQ_REPEAT_CHK_STATS_EN.
package seq_chk_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chk_state_e;

    localparam int REP_W = 8;

    // Increment that sticks at the all-ones value of a w-bit counter (w <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/seq_repeat_chk_chan.sv
// One checker channel for a |=> b[*MIN_REP:MAX_REP] ##1 c.
// Optional pass/fail counters under SEQ_REPEAT_CHK_STATS_EN.
module seq_repeat_chk_chan
    import seq_chk_pkg::*;
#(
    parameter int MIN_REP = 0,
    parameter int MAX_REP = 2
`ifdef SEQ_REPEAT_CHK_STATS_EN
    ,
    parameter int CNT_W   = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    output logic             busy,
    output logic             pass,
    output logic             fail,
`ifdef SEQ_REPEAT_CHK_STATS_EN
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
`endif
    output logic [REP_W-1:0] rep_cnt
);

    localparam logic [REP_W:0] MIN_R = (REP_W + 1)'(MIN_REP);
    localparam logic [REP_W:0] MAX_R = (REP_W + 1)'(MAX_REP);

    chk_state_e       state_q, state_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic [REP_W:0]   rep_inc;
    logic             min_ok;
    logic             max_ok;

    // Bounds are tested on count+1 so a zero bound never becomes a constant compare.
    always_comb begin
        rep_inc = {1'b0, rep_cnt_q} + (REP_W + 1)'(1);
        min_ok  = rep_inc > MIN_R;
        max_ok  = rep_inc <= MAX_R;
    end

    always_comb begin
        state_d   = state_q;
        rep_cnt_d = rep_cnt_q;
        pass_d    = 1'b0;
        fail_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en && a) begin
                    state_d   = RUN;
                    rep_cnt_d = '0;
                end
            end
            RUN: begin
                if (c) begin
                    pass_d    = min_ok;
                    fail_d    = !min_ok;
                    state_d   = IDLE;
                    rep_cnt_d = '0;
                end else if (b && max_ok) begin
                    rep_cnt_d = rep_inc[REP_W-1:0];
                end else begin
                    fail_d    = 1'b1;
                    state_d   = IDLE;
                    rep_cnt_d = '0;
                end
            end
            default: begin
                state_d   = IDLE;
                rep_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rep_cnt_q <= '0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rep_cnt_q <= rep_cnt_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
        end
    end

    assign busy    = (state_q == RUN);
    assign pass    = pass_q;
    assign fail    = fail_q;
    assign rep_cnt = rep_cnt_q;

`ifdef SEQ_REPEAT_CHK_STATS_EN
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;

    // Counters advance on the same edge that raises the pulse they count.
    always_comb begin
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        if (pass_d) pass_cnt_d = CNT_W'(sat_inc(32'(pass_cnt_q), CNT_W));
        if (fail_d) fail_cnt_d = CNT_W'(sat_inc(32'(fail_cnt_q), CNT_W));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign pass_cnt = pass_cnt_q;
    assign fail_cnt = fail_cnt_q;
`endif

endmodule

// File: rtl/seq_repeat_chk.sv
// CH independent repeat-sequence checkers sharing one enable.
// Optional per-channel pass/fail counters under SEQ_REPEAT_CHK_STATS_EN.
module seq_repeat_chk
    import seq_chk_pkg::*;
#(
    parameter int CH      = 1,
    parameter int MIN_REP = 0,
    parameter int MAX_REP = 2,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [CH-1:0]             a,
    input  logic [CH-1:0]             b,
    input  logic [CH-1:0]             c,
    output logic [CH-1:0]             busy,
    output logic [CH-1:0]             pass,
    output logic [CH-1:0]             fail,
`ifdef SEQ_REPEAT_CHK_STATS_EN
    output logic [CH-1:0][CNT_W-1:0]  pass_cnt,
    output logic [CH-1:0][CNT_W-1:0]  fail_cnt,
`endif
    output logic [CH-1:0][REP_W-1:0]  rep_cnt
);

    // Reject configurations the channel logic cannot represent.
    if (CH < 1 || CH > 16) begin : g_bad_ch
        $error("seq_repeat_chk: CH out of range");
    end
    if (MIN_REP < 0 || MAX_REP < MIN_REP || MAX_REP > 255) begin : g_bad_rep
        $error("seq_repeat_chk: repeat bounds out of range");
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt
        $error("seq_repeat_chk: CNT_W out of range");
    end

    for (genvar i = 0; i < CH; i++) begin : g_chan
        seq_repeat_chk_chan #(
            .MIN_REP (MIN_REP),
            .MAX_REP (MAX_REP)
`ifdef SEQ_REPEAT_CHK_STATS_EN
            ,
            .CNT_W   (CNT_W)
`endif
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en),
            .a        (a[i]),
            .b        (b[i]),
            .c        (c[i]),
            .busy     (busy[i]),
            .pass     (pass[i]),
            .fail     (fail[i]),
`ifdef SEQ_REPEAT_CHK_STATS_EN
            .pass_cnt (pass_cnt[i]),
            .fail_cnt (fail_cnt[i]),
`endif
            .rep_cnt  (rep_cnt[i])
        );
    end

endmodule

// File: tb/tb_seq_repeat_chk.sv
// Bench for seq_repeat_chk: two instances (MIN_REP 0 and 1) driven with shared inputs.
// Counter checks are compiled in with SEQ_REPEAT_CHK_STATS_EN.
module tb_seq_repeat_chk;

    localparam int CH = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic [CH-1:0] a = '0, b = '0, c = '0;

    logic [CH-1:0]      busy0, pass0, fail0, busy1, pass1, fail1;
    logic [CH-1:0][7:0] rep0, rep1;
`ifdef SEQ_REPEAT_CHK_STATS_EN
    logic [CH-1:0][15:0] pcnt0, fcnt0;
    logic [CH-1:0][1:0]  pcnt1, fcnt1;
`endif

    always #5 clk = ~clk;

    seq_repeat_chk #(.CH(CH), .MIN_REP(0), .MAX_REP(2), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .c(c),
        .busy(busy0), .pass(pass0), .fail(fail0),
`ifdef SEQ_REPEAT_CHK_STATS_EN
        .pass_cnt(pcnt0), .fail_cnt(fcnt0),
`endif
        .rep_cnt(rep0)
    );

    seq_repeat_chk #(.CH(CH), .MIN_REP(1), .MAX_REP(2), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .c(c),
        .busy(busy1), .pass(pass1), .fail(fail1),
`ifdef SEQ_REPEAT_CHK_STATS_EN
        .pass_cnt(pcnt1), .fail_cnt(fcnt1),
`endif
        .rep_cnt(rep1)
    );

    // Reference model: an attempt is remembered only by the cycle it started on;
    // the number of accepted b cycles is the elapsed time since then.
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int start_cyc[2][CH];
    int exp_pc[2][CH];
    int exp_fc[2][CH];
    int min_rep[2] = '{0, 1};
    int max_rep[2] = '{2, 2};
    int cnt_cap[2] = '{65535, 3};
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < CH; i++) begin
                start_cyc[d][i] = -1;
                exp_pc[d][i] = 0;
                exp_fc[d][i] = 0;
            end
        exp_q.delete();
    endtask

    task automatic model_edge();
        logic [CH-1:0]   bz, ps, fl;
        logic [CH*8-1:0] rp;
        int n;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            bz = '0; ps = '0; fl = '0; rp = '0;
            for (int i = 0; i < CH; i++) begin
                if (start_cyc[d][i] < 0) begin
                    if (en && a[i]) start_cyc[d][i] = cyc;
                end else begin
                    n = cyc - start_cyc[d][i] - 1;
                    if (c[i]) begin
                        if (n >= min_rep[d]) ps[i] = 1'b1;
                        else fl[i] = 1'b1;
                        start_cyc[d][i] = -1;
                    end else if (!(b[i] && n < max_rep[d])) begin
                        fl[i] = 1'b1;
                        start_cyc[d][i] = -1;
                    end
                end
                if (ps[i] && exp_pc[d][i] < cnt_cap[d]) exp_pc[d][i]++;
                if (fl[i] && exp_fc[d][i] < cnt_cap[d]) exp_fc[d][i]++;
                bz[i] = (start_cyc[d][i] >= 0);
                if (bz[i]) rp[i*8 +: 8] = 8'(cyc - start_cyc[d][i]);
            end
            exp_q.push_back(32'({bz, fl, ps}));
            exp_q.push_back(32'(rp));
        end
    endtask

    task automatic check_all();
        chk("d0_busy_fail_pass", 32'({busy0, fail0, pass0}), exp_q.pop_front());
        chk("d0_rep_cnt", 32'(rep0), exp_q.pop_front());
        chk("d1_busy_fail_pass", 32'({busy1, fail1, pass1}), exp_q.pop_front());
        chk("d1_rep_cnt", 32'(rep1), exp_q.pop_front());
`ifdef SEQ_REPEAT_CHK_STATS_EN
        chk("d0_pass_cnt", 32'(pcnt0), {16'(exp_pc[0][1]), 16'(exp_pc[0][0])});
        chk("d0_fail_cnt", 32'(fcnt0), {16'(exp_fc[0][1]), 16'(exp_fc[0][0])});
        chk("d1_pass_cnt", 32'(pcnt1), 32'({2'(exp_pc[1][1]), 2'(exp_pc[1][0])}));
        chk("d1_fail_cnt", 32'(fcnt1), 32'({2'(exp_fc[1][1]), 2'(exp_fc[1][0])}));
`endif
    endtask

    task automatic step(input logic e, input logic [CH-1:0] aa, input logic [CH-1:0] bb,
                        input logic [CH-1:0] cc);
        en = e; a = aa; b = bb; c = cc;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_d0"}, 32'({busy0, fail0, pass0, rep0}), 32'd0);
        chk({tag, "_d1"}, 32'({busy1, fail1, pass1, rep1}), 32'd0);
`ifdef SEQ_REPEAT_CHK_STATS_EN
        chk({tag, "_cnt"}, 32'({pcnt0, fcnt0}) | 32'({pcnt1, fcnt1}), 32'd0);
`endif
    endtask

    initial begin
        reset_model();
        #2;
        check_quiet("reset_state");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // First attempt accepted at the first edge after reset release
        step(1'b1, 2'b01, 2'b00, 2'b00);
        chk("first_accept_busy", 32'(busy0), 32'h1);
        step(1'b1, 2'b00, 2'b01, 2'b00);
        step(1'b1, 2'b00, 2'b00, 2'b01);
        chk("one_rep_pass", 32'(pass0), 32'h1);
        chk("one_rep_busy", 32'(busy0), 32'h0);
        step(1'b1, 2'b00, 2'b00, 2'b00);

        // Zero repeats: passes with MIN_REP 0, fails with MIN_REP 1; a during RUN ignored
        step(1'b1, 2'b01, 2'b00, 2'b00);
        step(1'b1, 2'b01, 2'b00, 2'b01);
        chk("zero_rep_pass_min0", 32'(pass0), 32'h1);
        chk("zero_rep_fail_min1", 32'(fail1), 32'h1);
        chk("a_ignored_busy", 32'(busy1), 32'h0);
        step(1'b1, 2'b00, 2'b00, 2'b00);

        // Third b exceeds MAX_REP
        step(1'b1, 2'b01, 2'b00, 2'b00);
        step(1'b1, 2'b00, 2'b01, 2'b00);
        step(1'b1, 2'b00, 2'b01, 2'b00);
        chk("max_rep_count", 32'(rep0[0]), 32'd2);
        step(1'b1, 2'b00, 2'b01, 2'b00);
        chk("over_max_fail", 32'(fail0), 32'h1);
        step(1'b1, 2'b00, 2'b00, 2'b00);

        // Channel 0 passes while channel 1 fails on the same edge
        step(1'b1, 2'b11, 2'b00, 2'b00);
        step(1'b1, 2'b00, 2'b11, 2'b00);
        step(1'b1, 2'b00, 2'b00, 2'b01);
        chk("split_pass", 32'(pass0), 32'h1);
        chk("split_fail", 32'(fail0), 32'h2);
        step(1'b1, 2'b00, 2'b00, 2'b00);

        // Enable low neither starts nor aborts
        step(1'b1, 2'b01, 2'b00, 2'b00);
        step(1'b0, 2'b00, 2'b01, 2'b00);
        step(1'b0, 2'b10, 2'b00, 2'b01);
        chk("en_low_keeps_attempt", 32'(pass0), 32'h1);
        chk("en_low_no_start", 32'(busy0), 32'h0);

        // Reset mid-attempt discards it
        step(1'b1, 2'b11, 2'b00, 2'b00);
        step(1'b1, 2'b00, 2'b11, 2'b00);
        rst_n = 1'b0;
        #1;
        check_quiet("async_reset");
        reset_model();
        @(posedge clk);
        #1;
        check_quiet("held_reset");
        rst_n = 1'b1;

        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 7) != 0),
                 {1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0)},
                 {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))},
                 {1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0)});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
